// File: rtl/hash_uart_pkg.sv
// Shared types and helpers for the MD6 digest UART transmitter (and a future receiver).
package hash_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Byte count for a digest of d bits, clamped to what the hash register holds.
  function automatic logic [63:0] ceil_bytes(input logic [63:0] d, input int hash_w);
    logic [63:0] c;
    logic [63:0] cap;
    c   = (d + 64'd7) >> 3;
    cap = 64'(hash_w / 8);
    return (c > cap) ? cap : c;
  endfunction

endpackage

// File: rtl/hash_uart_tx_baud.sv
// Bit-period timer: tick marks the last clock of every CLKS_PER_BIT-cycle bit period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr || tick) cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/hash_uart_tx.sv
// Serialises the first ceil(d_bits/8) digest bytes, MSB byte first, as 8N1 frames on TxD.
// Optional even parity bit per frame when HASH_UART_TX_PARITY_EN is defined.
module hash_uart_tx
  import hash_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int HASH_W       = 512,
  parameter int LEN_W        = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [HASH_W-1:0] hash_in,
  input  logic [LEN_W-1:0]  d_bits,
  output logic              TxD,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  bytes_sent
);

  localparam int BW = $clog2(UART_DATA_BITS);

  state_e                      state;
  logic   [HASH_W-1:0]         shreg;
  logic   [LEN_W:0]            nbytes;
  logic   [LEN_W:0]            nb_calc;
  logic   [BW-1:0]             bit_idx;
  logic                        stop_cnt;
  logic   [UART_DATA_BITS-1:0] cur_byte;
  logic                        tick;
  logic                        clr;
  logic                        accept;
  logic                        stop_last;
  logic                        last_byte;
  logic                        advance;
  logic                        line_bit;

  assign nb_calc   = (LEN_W+1)'(ceil_bytes(64'(d_bits), HASH_W));
  assign accept    = (state == IDLE) && start;
  assign cur_byte  = shreg[HASH_W-1 -: UART_DATA_BITS];
  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
  assign last_byte = (((LEN_W+1)'(bytes_sent) + (LEN_W+1)'(1)) == nbytes);
  assign advance   = (state == STOP) && tick && stop_last && !last_byte;

  // Timer is held at zero outside a transfer; every other state change lands on a tick,
  // where the counter wraps to zero, so each state starts with a fresh bit period.
  assign clr = (state == IDLE) || (state == DONE);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    line_bit = 1'b1;
    case (state)
      START:  line_bit = 1'b0;
      DATA:   line_bit = cur_byte[bit_idx];
`ifdef HASH_UART_TX_PARITY_EN
      PARITY: line_bit = ^cur_byte;
`endif
      default: line_bit = 1'b1;
    endcase
  end

  // Control path; TxD is registered so the line changes one edge after the state does.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bytes_sent <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      TxD        <= 1'b1;
    end else begin
      done <= 1'b0;
      TxD  <= line_bit;
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            bytes_sent <= '0;
            state      <= (nb_calc == '0) ? DONE : START;
          end
        end
        START: begin
          if (tick) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == BW'(UART_DATA_BITS - 1)) begin
              stop_cnt <= 1'b0;
`ifdef HASH_UART_TX_PARITY_EN
              state    <= PARITY;
`else
              state    <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
`ifdef HASH_UART_TX_PARITY_EN
        PARITY: begin
          if (tick) state <= STOP;
        end
`endif
        STOP: begin
          if (tick) begin
            if (stop_last) begin
              bytes_sent <= bytes_sent + LEN_W'(1);
              state      <= last_byte ? DONE : START;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data path: digest captured at acceptance, shifted one byte per completed frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg  <= hash_in;
      nbytes <= nb_calc;
    end else if (advance) begin
      shreg  <= shreg << UART_DATA_BITS;
    end
  end

endmodule

// File: tb/tb_hash_uart_tx.sv
// Directed bench for hash_uart_tx: per-cycle line/handshake model plus mid-bit byte decode.
module tb_hash_uart_tx;

  localparam int C      = 4;
  localparam int HASH_W = 512;
  localparam int LEN_W  = 16;
`ifdef HASH_UART_TX_PARITY_EN
  localparam int SB = 2;
  localparam int P  = 1;
`else
  localparam int SB = 1;
  localparam int P  = 0;
`endif
  localparam int F = (9 + SB + P) * C;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [HASH_W-1:0] hash_in;
  logic [LEN_W-1:0]  d_bits;
  logic              TxD;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  bytes_sent;

  int n_checks = 0;
  int n_errors = 0;

  hash_uart_tx #(
    .CLKS_PER_BIT (C),
    .HASH_W       (HASH_W),
    .LEN_W        (LEN_W),
    .STOP_BITS    (SB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .hash_in    (hash_in),
    .d_bits     (d_bits),
    .TxD        (TxD),
    .busy       (busy),
    .done       (done),
    .bytes_sent (bytes_sent)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_xfer(input string tag, input logic [HASH_W-1:0] h, input int d,
                          input int nb, input int disturb_at, input int reset_at);
    int wave_err, done_err, busy_err, bs_err, last, pos, b, w, slot, exp_bs;
    logic [7:0] exp_b;
    logic [7:0] rx;
    logic       e;
    bit         aborted;
    wave_err = 0; done_err = 0; busy_err = 0; bs_err = 0; aborted = 0;
    rx = '0; exp_b = '0;
    @(negedge clk);
    hash_in = h;
    d_bits  = LEN_W'(d);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq({tag, "_busy_accept"}, 64'(busy), 64'd1);
    check_eq({tag, "_txd_accept"}, 64'(TxD), 64'd1);
    last = nb * F + 1;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      if (k == reset_at) begin
        aborted = 1;
        break;
      end
      if (k < last) begin
        pos   = k - 1;
        b     = pos / F;
        w     = pos % F;
        slot  = w / C;
        exp_b = h[HASH_W-1-8*b -: 8];
        if (slot == 0)                e = 1'b0;
        else if (slot <= 8)           e = exp_b[slot-1];
        else if (P == 1 && slot == 9) e = ^exp_b;
        else                          e = 1'b1;
        if (TxD !== e) wave_err++;
        if (slot >= 1 && slot <= 8 && (w % C) == C / 2) rx[slot-1] = TxD;
        if (w == F - 1) check_eq($sformatf("%s_byte%0d", tag, b), 64'(rx), 64'(exp_b));
      end else if (TxD !== 1'b1) begin
        wave_err++;
      end
      if (done !== (k == last)) done_err++;
      if (busy !== (k < last)) busy_err++;
      exp_bs = (k / F < nb) ? k / F : nb;
      if (bytes_sent !== LEN_W'(exp_bs)) bs_err++;
      if (k == disturb_at) begin
        start   = 1'b1;
        hash_in = ~h;
      end else begin
        start = 1'b0;
      end
      if (k == reset_at - 1) reset = 1'b1;
    end
    check_eq({tag, "_wave"}, 64'(wave_err), 64'd0);
    check_eq({tag, "_bytes_sent_trace"}, 64'(bs_err), 64'd0);
    if (aborted) begin
      check_eq({tag, "_rst_txd"}, 64'(TxD), 64'd1);
      check_eq({tag, "_rst_busy"}, 64'(busy), 64'd0);
      check_eq({tag, "_rst_done"}, 64'(done), 64'd0);
      check_eq({tag, "_rst_bytes_sent"}, 64'(bytes_sent), 64'd0);
      reset = 1'b0;
      repeat (2 * F) @(posedge clk);
      #1;
      check_eq({tag, "_rst_idle_txd"}, 64'(TxD), 64'd1);
      check_eq({tag, "_rst_idle_done"}, 64'(done), 64'd0);
    end else begin
      check_eq({tag, "_done_trace"}, 64'(done_err), 64'd0);
      check_eq({tag, "_busy_trace"}, 64'(busy_err), 64'd0);
      @(posedge clk); #1;
      check_eq({tag, "_done_pulse_end"}, 64'(done), 64'd0);
      check_eq({tag, "_busy_end"}, 64'(busy), 64'd0);
      check_eq({tag, "_bytes_sent_end"}, 64'(bytes_sent), 64'(nb));
    end
  endtask

  initial begin
    logic [HASH_W-1:0] h;
    reset   = 1'b1;
    start   = 1'b0;
    hash_in = '0;
    d_bits  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_txd", 64'(TxD), 64'd1);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_bytes_sent", 64'(bytes_sent), 64'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    h = '0;
    h[HASH_W-1 -: 16] = 16'hA53C;
    run_xfer("a53c", h, 16, 2, 0, 0);
    run_xfer("d0", h, 0, 0, 0, 0);
    h[HASH_W-17 -: 8] = 8'h81;
    run_xfer("d9", h, 9, 2, 0, 0);

    for (int i = 0; i < HASH_W / 32; i++) h[32*i +: 32] = $urandom();
    run_xfer("d512", h, 512, 64, 0, 0);
    for (int i = 0; i < HASH_W / 32; i++) h[32*i +: 32] = $urandom();
    run_xfer("d600", h, 600, 64, 0, 0);

    h = '0;
    h[HASH_W-1 -: 16] = 16'hA53C;
    run_xfer("restart", h, 16, 2, 15, 0);

    h = '0;
    h[HASH_W-1 -: 16] = 16'h00FF;
    run_xfer("rst22", h, 16, 2, 0, 22);

    h = '0;
    h[HASH_W-1 -: 8] = 8'h07;
    run_xfer("b07", h, 8, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
